// File: rtl/dma_line_engine.sv
// dma_line_engine: packs 32-bit words into 256-bit line writes and issues line reads; define DMA_RD_FIFO_EN for a 4-entry buffered read path
module dma_line_engine (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic         i_cmd_wr,
  input  logic [31:0]  i_cmd_addr,
  input  logic [15:0]  i_cmd_len,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  input  logic [31:0]  i_s_data,
  output logic         o_rd_valid,
  output logic [255:0] o_rd_data,
  input  logic         i_rd_ready,
  output logic         o_done,
  output logic         o_dma_rden,
  output logic         o_dma_wren,
  output logic [31:0]  o_dma_addr,
  output logic [255:0] o_dma_wdata,
  output logic [7:0]   o_dma_wstrb,
  output logic [7:0]   o_dma_winc,
  input  logic [255:0] i_dma_rdata,
  input  logic         i_dma_rvalid,
  input  logic         i_dma_gnt
);
  typedef enum logic [2:0] {IDLE, WR_FILL, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [26:0]  r_line;
  logic [2:0]   r_k, r_cnt, w_lane;
  logic [15:0]  r_left;
  logic [13:0]  r_issue, r_resp, w_nlines;
  logic [16:0]  w_len_up;
  logic [31:0]  r_buf [8];
  logic [7:0]   r_strb, r_winc;
  logic [255:0] w_wdata;
  logic         w_acc, w_cons, w_wgnt, w_rgnt, w_rd_act, w_resp, w_can_issue, w_fifo_empty, w_unused;

  assign w_len_up    = {1'b0, i_cmd_len} + 17'd7;
  assign w_nlines    = w_len_up[16:3];
  assign w_lane      = r_k + r_cnt;
  assign w_acc       = i_cmd_valid & o_cmd_ready;
  assign w_cons      = i_s_valid & o_s_ready;
  assign w_wgnt      = o_dma_wren & i_dma_gnt;
  assign w_rgnt      = o_dma_rden & i_dma_gnt;
  assign w_rd_act    = (r_state == RD_ISSUE) || (r_state == RD_WAIT);
  assign w_resp      = i_dma_rvalid & w_rd_act & (r_resp != 14'd0);
  assign w_unused    = ^{i_cmd_addr[1:0], i_rd_ready};

  assign o_cmd_ready = i_rst_n & (r_state == IDLE);
  assign o_s_ready   = i_rst_n & (r_state == WR_FILL);
  assign o_dma_wren  = i_rst_n & (r_state == WR_ISSUE);
  assign o_dma_rden  = i_rst_n & (r_state == RD_ISSUE) & w_can_issue;
  assign o_done      = i_rst_n & (r_state == DONE);
  assign o_dma_addr  = (o_dma_wren | o_dma_rden) ? {5'b0, r_line} : 32'd0;
  assign o_dma_wdata = o_dma_wren ? w_wdata : '0;
  assign o_dma_wstrb = o_dma_wren ? r_strb : 8'd0;
  assign o_dma_winc  = o_dma_wren ? r_winc : 8'd0;

  // flatten the lane buffer into one write line
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < 8; i++) w_wdata[i*32 +: 32] = r_buf[i];
  end

  // state register
  always_ff @(posedge i_clk) begin
    r_state <= !i_rst_n ? IDLE : w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_acc) w_next = (i_cmd_len == 16'd0) ? DONE : i_cmd_wr ? WR_FILL : RD_ISSUE;
      WR_FILL:  if (w_cons && (r_cnt == 3'd7 || r_left == 16'd1)) w_next = WR_ISSUE;
      WR_ISSUE: if (i_dma_gnt) w_next = (r_left == 16'd0) ? DONE : WR_FILL;
      RD_ISSUE: if (w_rgnt && r_issue == 14'd1) w_next = RD_WAIT;
      RD_WAIT:  if (r_resp == 14'd0 && w_fifo_empty) w_next = DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // command capture, lane packing and line/response counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_line  <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_left  <= '0;
      r_issue <= '0;
      r_resp  <= '0;
      r_strb  <= '0;
      r_winc  <= '0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else begin
      if (w_acc) begin
        r_line  <= i_cmd_addr[31:5];
        r_k     <= i_cmd_addr[4:2];
        r_cnt   <= '0;
        r_left  <= i_cmd_len;
        r_issue <= w_nlines;
        r_resp  <= w_nlines;
      end
      if (w_cons) begin
        r_buf[w_lane]  <= i_s_data;
        r_strb[w_lane] <= 1'b1;
        r_winc[w_lane] <= w_lane < r_k;
        r_cnt          <= r_cnt + 3'd1;
        r_left         <= r_left - 16'd1;
      end
      if (w_wgnt) begin
        r_line <= r_line + 27'd1;
        r_cnt  <= '0;
        r_strb <= '0;
        r_winc <= '0;
        for (int i = 0; i < 8; i++) r_buf[i] <= '0;
      end
      if (w_rgnt) begin
        r_line  <= r_line + 27'd1;
        r_issue <= r_issue - 14'd1;
      end
      if (w_resp) r_resp <= r_resp - 14'd1;
    end
  end

`ifdef DMA_RD_FIFO_EN
  logic [255:0] r_fifo [4];
  logic [1:0]   r_wp, r_rp;
  logic [2:0]   r_occ, r_out;
  logic         w_pop;
  assign w_pop        = o_rd_valid & i_rd_ready;
  assign o_rd_valid   = i_rst_n & (r_occ != 3'd0);
  assign o_rd_data    = o_rd_valid ? r_fifo[r_rp] : '0;
  assign w_fifo_empty = r_occ == 3'd0;
  assign w_can_issue  = ({1'b0, r_occ} + {1'b0, r_out}) < 4'd4;

  // read line FIFO; r_out tracks reads granted but not yet returned
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
      r_out <= '0;
    end else begin
      if (w_resp) begin
        r_fifo[r_wp] <= i_dma_rdata;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_occ <= r_occ + {2'b0, w_resp} - {2'b0, w_pop};
      r_out <= r_out + {2'b0, w_rgnt} - {2'b0, w_resp};
    end
  end
`else
  assign o_rd_valid   = i_rst_n & w_resp;
  assign o_rd_data    = o_rd_valid ? i_dma_rdata : '0;
  assign w_fifo_empty = 1'b1;
  assign w_can_issue  = 1'b1;
`endif
endmodule

// File: tb/tb_dma_line_engine.sv
// tb_dma_line_engine: directed checks of line packing, grant hold, read issue and reset abort
module tb_dma_line_engine;
  logic         clk, i_rst_n, i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [31:0]  i_cmd_addr;
  logic [15:0]  i_cmd_len;
  logic         i_s_valid, o_s_ready;
  logic [31:0]  i_s_data;
  logic         o_rd_valid, i_rd_ready, o_done, o_dma_rden, o_dma_wren;
  logic [255:0] o_rd_data, o_dma_wdata, i_dma_rdata;
  logic [31:0]  o_dma_addr;
  logic [7:0]   o_dma_wstrb, o_dma_winc;
  logic         i_dma_rvalid, i_dma_gnt;

  dma_line_engine dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready), .o_done(o_done),
    .o_dma_rden(o_dma_rden), .o_dma_wren(o_dma_wren), .o_dma_addr(o_dma_addr),
    .o_dma_wdata(o_dma_wdata), .o_dma_wstrb(o_dma_wstrb), .o_dma_winc(o_dma_winc),
    .i_dma_rdata(i_dma_rdata), .i_dma_rvalid(i_dma_rvalid), .i_dma_gnt(i_dma_gnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int errors, checks, cyc, gnt_wait, wcnt;
  int n_wren, n_rden, n_beats, n_rg, n_lines, n_done, inflight, maxinf, acc_cyc, done_cyc;
  int sw_n, sw_i;
  logic [31:0]  sw [16];
  logic [31:0]  b_addr [4];
  logic [7:0]   b_strb [4], b_winc [4];
  logic [255:0] b_data [4];
  logic [31:0]  ra [8];
  logic [255:0] l_data [8];
  logic         prev_wait, p0v, p1v;
  logic [31:0]  p0a, p1a;
  logic [303:0] prev_beat;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] lined(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {a[15:0], 16'(i)};
    return r;
  endfunction

  task automatic tick();
    logic acc, cons, wg, rg, take, req;
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    acc  = i_cmd_valid & o_cmd_ready;
    cons = i_s_valid & o_s_ready;
    wg   = o_dma_wren & i_dma_gnt;
    rg   = o_dma_rden & i_dma_gnt;
    a    = o_dma_addr;
    if (o_dma_wren) n_wren++;
    if (o_dma_rden) n_rden++;
    if (prev_wait && o_dma_wren) chk("hold_stable", {o_dma_addr, o_dma_wstrb, o_dma_winc, o_dma_wdata}, prev_beat);
    prev_wait = o_dma_wren & ~i_dma_gnt;
    prev_beat = {o_dma_addr, o_dma_wstrb, o_dma_winc, o_dma_wdata};
    if (wg && n_beats < 4) begin
      b_addr[n_beats] = o_dma_addr;
      b_strb[n_beats] = o_dma_wstrb;
      b_winc[n_beats] = o_dma_winc;
      b_data[n_beats] = o_dma_wdata;
    end
    if (wg) n_beats++;
    if (rg && n_rg < 8) ra[n_rg] = o_dma_addr;
    if (rg) begin n_rg++; inflight++; end
`ifdef DMA_RD_FIFO_EN
    take = o_rd_valid & i_rd_ready;
`else
    take = o_rd_valid;
`endif
    if (take && n_lines < 8) l_data[n_lines] = o_rd_data;
    if (take) begin n_lines++; inflight--; end
    if (inflight > maxinf) maxinf = inflight;
    if (o_done) begin n_done++; done_cyc = cyc; end
    if (acc) acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (acc) i_cmd_valid = 0;
    if (cons) sw_i++;
    i_s_valid = sw_i < sw_n;
    i_s_data  = (sw_i < sw_n) ? sw[sw_i] : 32'd0;
    p1v = p0v; p1a = p0a; p0v = rg; p0a = a;
    i_dma_rvalid = p1v;
    i_dma_rdata  = p1v ? lined(p1a) : '0;
    if (wg | rg) wcnt = 0;
    req = o_dma_wren | o_dma_rden;
    if (!req) wcnt = 0;
    i_dma_gnt = req && (wcnt >= gnt_wait);
    if (req && !i_dma_gnt) wcnt++;
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] len, input logic [31:0] base);
    n_wren = 0; n_rden = 0; n_beats = 0; n_rg = 0; n_lines = 0; n_done = 0;
    inflight = 0; maxinf = 0; acc_cyc = -100; done_cyc = -100; prev_wait = 0;
    for (int j = 0; j < 16; j++) sw[j] = base + j;
    sw_n = wr ? int'(len) : 0;
    sw_i = 0;
    i_s_valid = sw_n > 0;
    i_s_data  = sw[0];
    i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_len = len;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] len, input logic [31:0] base, input int hold);
    start_cmd(wr, addr, len, base);
    for (int t = 0; t < 300 && n_done == 0; t++) begin
      i_rd_ready = t >= hold;
      tick();
    end
    i_rd_ready = 1;
    tick();
    tick();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; gnt_wait = 0; wcnt = 0;
    i_rst_n = 0; i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = 0; i_cmd_len = 0;
    i_s_valid = 0; i_s_data = 0; i_rd_ready = 0; i_dma_rdata = 0; i_dma_rvalid = 0; i_dma_gnt = 0;
    p0v = 0; p1v = 0; p0a = 0; p1a = 0; sw_n = 0; sw_i = 0; prev_wait = 0; prev_beat = 0;
    tick();
    tick();
    chk("reset_outputs", {o_cmd_ready, o_s_ready, o_done, o_dma_wren, o_dma_rden, o_rd_valid, o_dma_addr, o_dma_wstrb}, 0);
    i_rst_n = 1;
    #1;
    chk("ready_after_reset", o_cmd_ready, 1);

    run_cmd(1, 32'h100, 8, 32'h1000, 0);
    chk("w1_beats", n_beats, 1);
    chk("w1_addr", b_addr[0], 8);
    chk("w1_strb", b_strb[0], 8'hFF);
    chk("w1_winc", b_winc[0], 8'h00);
    chk("w1_data", b_data[0], {32'h1007, 32'h1006, 32'h1005, 32'h1004, 32'h1003, 32'h1002, 32'h1001, 32'h1000});
    chk("w1_done", n_done, 1);

    run_cmd(1, 32'h10C, 8, 32'h2000, 0);
    chk("w2_beats", n_beats, 1);
    chk("w2_addr", b_addr[0], 8);
    chk("w2_strb", b_strb[0], 8'hFF);
    chk("w2_winc", b_winc[0], 8'h07);
    chk("w2_data", b_data[0], {32'h2004, 32'h2003, 32'h2002, 32'h2001, 32'h2000, 32'h2007, 32'h2006, 32'h2005});
    chk("w2_done", n_done, 1);

    gnt_wait = 3;
    run_cmd(1, 32'h0, 10, 32'h4000, 0);
    gnt_wait = 0;
    chk("w3_beats", n_beats, 2);
    chk("w3_addr0", b_addr[0], 0);
    chk("w3_strb0", b_strb[0], 8'hFF);
    chk("w3_data0", b_data[0], {32'h4007, 32'h4006, 32'h4005, 32'h4004, 32'h4003, 32'h4002, 32'h4001, 32'h4000});
    chk("w3_addr1", b_addr[1], 1);
    chk("w3_strb1", b_strb[1], 8'h03);
    chk("w3_winc1", b_winc[1], 8'h00);
    chk("w3_data1", b_data[1], {192'h0, 32'h4009, 32'h4008});
    chk("w3_wren_cycles", n_wren, 8);
    chk("w3_done", n_done, 1);

    run_cmd(1, 32'hFFFF_FFE0, 9, 32'h3000, 0);
    chk("wrap_addr0", b_addr[0], 32'h07FF_FFFF);
    chk("wrap_addr1", b_addr[1], 0);
    chk("wrap_strb1", b_strb[1], 8'h01);
    chk("wrap_data1", b_data[1], {224'h0, 32'h3008});

    run_cmd(0, 32'h40, 20, 32'h0, 10);
    chk("r_grants", n_rg, 3);
    chk("r_addr0", ra[0], 2);
    chk("r_addr1", ra[1], 3);
    chk("r_addr2", ra[2], 4);
    chk("r_lines", n_lines, 3);
    chk("r_line0", l_data[0], lined(2));
    chk("r_line1", l_data[1], lined(3));
    chk("r_line2", l_data[2], lined(4));
    chk("r_inflight_le4", maxinf <= 4, 1);
    chk("r_no_wren", n_wren, 0);
    chk("r_done", n_done, 1);

    run_cmd(1, 32'h80, 0, 32'h0, 0);
    chk("z_done_latency", done_cyc - acc_cyc, 1);
    chk("z_no_access", n_wren + n_rden, 0);
    chk("z_done", n_done, 1);

    gnt_wait = 1000;
    start_cmd(1, 32'h0, 8, 32'h5000);
    for (int t = 0; t < 50 && n_wren == 0; t++) tick();
    chk("rst_reached_issue", n_wren != 0, 1);
    i_rst_n = 0; sw_n = 0; i_s_valid = 0;
    tick();
    chk("rst_wren_off", o_dma_wren, 0);
    tick();
    i_rst_n = 1;
    gnt_wait = 0;
    for (int t = 0; t < 5; t++) tick();
    chk("rst_no_done", n_done, 0);
    run_cmd(1, 32'h20, 8, 32'h6000, 0);
    chk("rst_next_beats", n_beats, 1);
    chk("rst_next_addr", b_addr[0], 1);
    chk("rst_next_strb", b_strb[0], 8'hFF);
    chk("rst_next_data", b_data[0], {32'h6007, 32'h6006, 32'h6005, 32'h6004, 32'h6003, 32'h6002, 32'h6001, 32'h6000});
    chk("rst_next_done", n_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
